// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by packet sources and sinks.
// The master drives the payload and tvalid. The slave drives tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// Bursts of fixed-length AXI4-Stream packets with payload {packet index, word index},
// programmed per burst and never truncated by backpressure or stop.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no burst; waits for start_i and latches the burst setup
// ST_SEND | tvalid high; words advance on each handshake
// ST_GAP  | tvalid low for gap_q cycles between packets
module axi4_stream_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [LEN_WIDTH-1:0]  pkt_len_i,
  input  logic [GAP_WIDTH-1:0]  gap_i,
  input  logic [CNT_WIDTH-1:0]  pkt_amount_i,
  input  logic [DEST_WIDTH-1:0] dest_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  pkts_sent_o,
  axi4_stream_if.master         pkt_o
);

  localparam int PW = CNT_WIDTH + LEN_WIDTH;
  localparam int MW = (PW > DATA_WIDTH) ? PW : DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [CNT_WIDTH-1:0]  amt_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LEN_WIDTH-1:0]  word_idx_q;
  logic [CNT_WIDTH-1:0]  pkt_idx_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;
  logic [CNT_WIDTH-1:0]  pkts_sent_q;
  logic                  stop_seen_q;
  logic                  done_q;

  logic                  send;
  logic                  hs;
  logic                  last_word;
  logic                  burst_end;
  logic                  finish;
  logic [CNT_WIDTH-1:0]  pkt_idx_inc;
  logic [MW-1:0]         payload_w;

  assign send        = (state_q == ST_SEND);
  assign hs          = send && pkt_o.tready;
  assign last_word   = (word_idx_q == len_q);
  assign pkt_idx_inc = pkt_idx_q + CNT_WIDTH'(1);

  // A stop arriving on the tlast cycle itself also ends the burst.
  assign burst_end = stop_seen_q || stop_i ||
                     ((amt_q != '0) && (pkt_idx_inc == amt_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs && last_word) begin
          if (burst_end) begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end else if (gap_q != '0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q       <= '0;
      gap_q       <= '0;
      amt_q       <= '0;
      dest_q      <= '0;
      id_q        <= '0;
      word_idx_q  <= '0;
      pkt_idx_q   <= '0;
      gap_cnt_q   <= '0;
      pkts_sent_q <= '0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q       <= pkt_len_i;
            gap_q       <= gap_i;
            amt_q       <= pkt_amount_i;
            dest_q      <= dest_i;
            id_q        <= id_i;
            word_idx_q  <= '0;
            pkt_idx_q   <= '0;
            stop_seen_q <= 1'b0;
          end
        end
        ST_SEND: begin
          if (stop_i) begin
            stop_seen_q <= 1'b1;
          end
          if (hs) begin
            if (last_word) begin
              word_idx_q  <= '0;
              pkt_idx_q   <= pkt_idx_inc;
              pkts_sent_q <= pkts_sent_q + CNT_WIDTH'(1);
              gap_cnt_q   <= gap_q;
            end else begin
              word_idx_q <= word_idx_q + LEN_WIDTH'(1);
            end
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Payload is gated by tvalid so everything reads zero outside SEND.
  assign payload_w = MW'({pkt_idx_q, word_idx_q});

  always_comb begin
    pkt_o.tuser    = '0;
    pkt_o.tuser[0] = send && (word_idx_q == '0);
  end

  assign pkt_o.tvalid = send;
  assign pkt_o.tdata  = send ? payload_w[DATA_WIDTH-1:0] : '0;
  assign pkt_o.tstrb  = send ? '1 : '0;
  assign pkt_o.tkeep  = send ? '1 : '0;
  assign pkt_o.tlast  = send && last_word;
  assign pkt_o.tdest  = send ? dest_q : '0;
  assign pkt_o.tid    = send ? id_q : '0;

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign pkts_sent_o = pkts_sent_q;

endmodule
